// File: rtl/div_clk_monitor_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding and
// the good-period window / timeout derivation from the divider parameters.
package div_clk_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQ,
        ST_TRACK,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    function automatic int good_lo(input int ratio, input int tol);
        return ratio - tol;
    endfunction

    function automatic int good_hi(input int ratio, input int tol);
        return ratio + tol;
    endfunction

    // First count value that can only mean a stalled divided clock.
    function automatic int tmo_val(input int ratio, input int tol);
        return ratio + tol + 1;
    endfunction

endpackage

// File: rtl/div_clk_monitor_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, resets to 0; reusable across the clock tree.
module sync_2ff (
    input  logic clk,
    input  logic rstb,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops use non-blocking assignments so each stage samples the pre-edge value of the one before.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures each divided-clock period in clk cycles, tracks lock and faults.
// Optional saturating bad-period counter is built only when DIV_MON_ERRCNT_EN is defined.
module div_clk_monitor
    import div_clk_monitor_pkg::*;
#(
    parameter int DIV_RATIO = 4,
    parameter int TOL       = 1,
    parameter int LOCK_CNT  = 4,
    parameter int CNT_W     = 8,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             div_clk_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_vld,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] GOOD_LO = CNT_W'(good_lo(DIV_RATIO, TOL));
    localparam logic [CNT_W-1:0] GOOD_HI = CNT_W'(good_hi(DIV_RATIO, TOL));
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(tmo_val(DIV_RATIO, TOL));
    localparam int               GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

    logic              s2;
    logic              s3;
    logic              rise;
    logic [CNT_W-1:0]  count;
    logic              good;
    logic              bad;
    logic              tmo;
    logic              tracking;
    state_t            state;
    logic [GOOD_W-1:0] good_cnt;

    sync_2ff u_sync (
        .clk  (clk),
        .rstb (rstb),
        .d    (div_clk_in),
        .q    (s2)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) s3 <= 1'b0;
        else       s3 <= s2;
    end

    assign rise = s2 & ~s3;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)                count <= '0;
        else if (rise)            count <= CNT_W'(1);
        else if (count != '1)     count <= count + CNT_W'(1);
    end

    // A rise landing on the timeout count is judged only as a (bad) period.
    assign tmo      = (count == TMO_VAL) && !rise;
    assign good     = rise && (count >= GOOD_LO) && (count <= GOOD_HI);
    assign bad      = rise && !good;
    assign tracking = (state == ST_TRACK) || (state == ST_LOCKED) || (state == ST_FAULT);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= ST_IDLE;
            good_cnt   <= '0;
            period_out <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
        end else if (!en) begin
            state      <= ST_IDLE;
            good_cnt   <= '0;
            period_out <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            period_vld <= rise && tracking;
            if (rise && tracking) period_out <= count;

            case (state)
                ST_IDLE: state <= ST_ACQ;
                ST_ACQ: begin
                    if (rise) begin
                        state    <= ST_TRACK;
                        good_cnt <= '0;
                    end
                end
                ST_TRACK, ST_FAULT: begin
                    if (good) begin
                        if (good_cnt == GOOD_LAST) begin
                            state    <= ST_LOCKED;
                            locked   <= 1'b1;
                            fault    <= 1'b0;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                        end
                    end else if (bad) begin
                        good_cnt <= '0;
                    end else if (tmo) begin
                        good_cnt <= '0;
                        if (state == ST_TRACK) state <= ST_ACQ;
                    end
                end
                ST_LOCKED: begin
                    if (bad || tmo) begin
                        state    <= ST_FAULT;
                        locked   <= 1'b0;
                        fault    <= 1'b1;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    locked <= 1'b0;
                    fault  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIV_MON_ERRCNT_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)                                        err_cnt <= '0;
        else if (!en)                                     err_cnt <= '0;
        else if ((bad || tmo) && tracking && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
`else
    assign err_cnt = '0;
`endif

endmodule
